// File: rtl/prog_mem_if.sv
// rtl/prog_mem_if.sv - loader-side load request and write stream for prog_mem
interface prog_mem_if #(
  parameter int DATA_W = 4
);
  logic              load_req;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output load_req, output wr_valid, output wr_data, input wr_ready);
  modport slave  (input load_req, input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - program memory with stream loader FSM; optional checksum via PROG_MEM_CHECKSUM_EN
module prog_mem #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o,
  prog_mem_if.slave         wr_if,
  output logic              cpu_n_rst_o,
  output logic              loading_o,
  output logic [DATA_W-1:0] chk_o
);

  localparam int DEPTH = 1 << ADDR_W;
  // Pointer is one bit wider than the address so the last slot is detected, never wrapped.
  localparam logic [ADDR_W:0] LAST_PTR = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {
    S_RUN,
    S_LOAD,
    S_FULL,
    S_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic              wr_en;
  logic              cpu_n_rst_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // State and write pointer registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_RELEASE;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
    end
  end

  // Next state, pointer advance and write strobe.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    wr_en   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (wr_if.load_req) begin
          state_d = S_LOAD;
          wptr_d  = '0;
        end
      end
      S_LOAD: begin
        // A word offered in the cycle load_req drops is still taken.
        if (wr_if.wr_valid) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 1'b1;
        end
        if (!wr_if.load_req) begin
          state_d = S_RELEASE;
        end else if (wr_if.wr_valid && (wptr_q == LAST_PTR)) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (!wr_if.load_req) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RELEASE;
      end
    endcase
  end

  // Program storage, cleared to LED-OFF instructions on reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= wr_if.wr_data;
    end
  end

  // CPU reset flop: released only on the edge that lands in RUN, so it never glitches.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cpu_n_rst_q <= 1'b0;
    end else begin
      cpu_n_rst_q <= (state_d == S_RUN);
    end
  end

`ifdef PROG_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;

  // Running XOR of accepted words, restarted on every new load session.
  always_comb begin
    chk_d = chk_q;
    if ((state_q == S_RUN) && wr_if.load_req) begin
      chk_d = '0;
    end else if (wr_en) begin
      chk_d = chk_q ^ wr_if.wr_data;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign chk_o = chk_q;
`else
  assign chk_o = '0;
`endif

  assign data_o         = mem_q[addr_i];
  assign wr_if.wr_ready = (state_q == S_LOAD);
  assign loading_o      = (state_q == S_LOAD) || (state_q == S_FULL);
  assign cpu_n_rst_o    = cpu_n_rst_q;

endmodule

// File: tb/tb_prog_mem.sv
// tb/tb_prog_mem.sv - scoreboard bench for prog_mem
module tb_prog_mem;

`ifdef PROG_MEM_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk;
  logic       n_rst;
  logic [0:0] addr;
  logic [3:0] data;
  logic       cpu_n_rst;
  logic       loading;
  logic [3:0] chk;

  prog_mem_if #(.DATA_W(4)) bus ();

  prog_mem #(.ADDR_W(1), .DATA_W(4)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .addr_i      (addr),
    .data_o      (data),
    .wr_if       (bus.slave),
    .cpu_n_rst_o (cpu_n_rst),
    .loading_o   (loading),
    .chk_o       (chk)
  );

  typedef struct {
    string      tag;
    logic [3:0] data;
    logic       nrst;
    logic       rdy;
    logic       ld;
    logic [3:0] chk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string field, input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s got %h want %h", tag, field, act, want);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares against the live outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.tag, "data", data, e.data);
      cmp(e.tag, "cpu_n_rst", {3'b0, cpu_n_rst}, {3'b0, e.nrst});
      cmp(e.tag, "wr_ready", {3'b0, bus.wr_ready}, {3'b0, e.rdy});
      cmp(e.tag, "loading", {3'b0, loading}, {3'b0, e.ld});
      cmp(e.tag, "chk", chk, e.chk);
    end
  end

  // One cycle: drive inputs just after posedge and queue the outputs expected for this cycle.
  task automatic cyc(input string tag, input logic rn, input logic lr, input logic wv,
                     input logic [3:0] wd, input logic a,
                     input logic [3:0] ed, input logic en, input logic er, input logic el,
                     input logic [3:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    n_rst        = rn;
    bus.load_req = lr;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    addr         = a;
    e.tag  = tag;
    e.data = ed;
    e.nrst = en;
    e.rdy  = er;
    e.ld   = el;
    e.chk  = CK ? ec : 4'h0;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst        = 1'b0;
    bus.load_req = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 4'h0;
    addr         = 1'b0;
    repeat (2) @(posedge clk);

    //   tag     rn lr wv wd    a     data  nr rdy ld chk
    // 1: reset values, address sweep, one RELEASE cycle
    cyc("t1_rst",  1, 0, 0, 4'h0, 0,  4'h0, 0, 0, 0, 4'h0);
    cyc("t1_a1",   1, 0, 0, 4'h0, 1,  4'h0, 1, 0, 0, 4'h0);
    cyc("t1_a0",   1, 1, 0, 4'h0, 0,  4'h0, 1, 0, 0, 4'h0);
    // 2: full two-word load
    cyc("t2_ld",   1, 1, 1, 4'h1, 0,  4'h0, 0, 1, 1, 4'h0);
    cyc("t2_w0",   1, 1, 1, 4'h0, 0,  4'h1, 0, 1, 1, 4'h1);
    cyc("t2_full", 1, 1, 1, 4'hF, 1,  4'h0, 0, 0, 1, 4'h1);
    cyc("t2_fign", 1, 0, 0, 4'h0, 1,  4'h0, 0, 0, 1, 4'h1);
    cyc("t2_rel",  1, 0, 0, 4'h0, 0,  4'h1, 0, 0, 0, 4'h1);
    cyc("t2_run",  1, 0, 0, 4'h0, 1,  4'h0, 1, 0, 0, 4'h1);
    // 3: partial load keeps old mem[1]
    cyc("t3_run",  1, 1, 0, 4'h0, 0,  4'h1, 1, 0, 0, 4'h1);
    cyc("t3_ld",   1, 1, 1, 4'hA, 0,  4'h1, 0, 1, 1, 4'h0);
    cyc("t3_w0",   1, 0, 0, 4'h0, 0,  4'hA, 0, 1, 1, 4'hA);
    cyc("t3_rel",  1, 0, 0, 4'h0, 1,  4'h0, 0, 0, 0, 4'hA);
    cyc("t3_run",  1, 0, 0, 4'h0, 0,  4'hA, 1, 0, 0, 4'hA);
    // 4: write in the same cycle load_req drops; stray writes ignored
    cyc("t4_run",  1, 1, 0, 4'h0, 0,  4'hA, 1, 0, 0, 4'hA);
    cyc("t4_ld",   1, 0, 1, 4'h5, 0,  4'hA, 0, 1, 1, 4'h0);
    cyc("t4_rel",  1, 0, 1, 4'h7, 0,  4'h5, 0, 0, 0, 4'h5);
    cyc("t4_run",  1, 0, 1, 4'h9, 0,  4'h5, 1, 0, 0, 4'h5);
    cyc("t4_m1",   1, 0, 0, 4'h0, 1,  4'h0, 1, 0, 0, 4'h5);
    // 6: checksum, load_req during RELEASE, re-entry clears chk
    cyc("t6_run",  1, 1, 0, 4'h0, 0,  4'h5, 1, 0, 0, 4'h5);
    cyc("t6_ld",   1, 1, 1, 4'h3, 0,  4'h5, 0, 1, 1, 4'h0);
    cyc("t6_w0",   1, 1, 1, 4'h6, 1,  4'h0, 0, 1, 1, 4'h3);
    cyc("t6_full", 1, 0, 0, 4'h0, 1,  4'h6, 0, 0, 1, 4'h5);
    cyc("t6_rel",  1, 1, 0, 4'h0, 0,  4'h3, 0, 0, 0, 4'h5);
    cyc("t6_run",  1, 1, 0, 4'h0, 0,  4'h3, 1, 0, 0, 4'h5);
    cyc("t6_reld", 1, 1, 1, 4'hC, 0,  4'h3, 0, 1, 1, 4'h0);
    // 5: asynchronous reset mid-load
    cyc("t5_w0",   1, 1, 0, 4'h0, 0,  4'hC, 0, 1, 1, 4'hC);
    cyc("t5_arst", 0, 1, 1, 4'hD, 0,  4'h0, 0, 0, 0, 4'h0);
    cyc("t5_a1",   0, 1, 1, 4'hD, 1,  4'h0, 0, 0, 0, 4'h0);
    cyc("t5_rel",  1, 1, 0, 4'h0, 0,  4'h0, 0, 0, 0, 4'h0);
    cyc("t5_run",  1, 1, 0, 4'h0, 1,  4'h0, 1, 0, 0, 4'h0);
    cyc("t5_ld",   1, 0, 0, 4'h0, 0,  4'h0, 0, 1, 1, 4'h0);
    cyc("t5_rel2", 1, 0, 0, 4'h0, 0,  4'h0, 0, 0, 0, 4'h0);
    cyc("t5_run2", 1, 0, 0, 4'h0, 1,  4'h0, 1, 0, 0, 4'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
